// File: rtl/i2c_pkg.sv
// Shared types and helpers for the CLK-domain I2C register-file slave.
package i2c_pkg;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h55;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    INDEX     = 4'd3,
    INDEX_ACK = 4'd4,
    WRITE     = 4'd5,
    WRITE_ACK = 4'd6,
    READ      = 4'd7,
    READ_MACK = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    SRC_RW,
    SRC_RO,
    SRC_ZERO
  } rd_src_e;

  // Region an index falls into: R/W file, read-only status, or unmapped.
  function automatic rd_src_e read_src(input logic [7:0] ptr, input int num_rw, input int num_ro);
    if (int'(ptr) < num_rw) return SRC_RW;
    if (int'(ptr) < num_rw + num_ro) return SRC_RO;
    return SRC_ZERO;
  endfunction

endpackage

// File: rtl/i2c_regfile_slave_if.sv
// I2C pin bundle: raw SCL/SDA inputs and the open-drain SDA pull-down enable.
interface i2c_regfile_slave_if;
  logic SCL_IN;
  logic SDA_IN;
  logic SDA_OE;

  modport slave  (input SCL_IN, input SDA_IN, output SDA_OE);
  modport master (output SCL_IN, output SDA_IN, input SDA_OE);
endinterface

// File: rtl/i2c_line_filter.sv
// Synchronises one raw bus line into CLK, rejects glitches shorter than
// FILTER_LEN cycles and flags single-cycle rise/fall events.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       level_d;
  logic [3:0] run;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b11;
      level   <= 1'b1;
      level_d <= 1'b1;
      run     <= '0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      if (sync[1] == level) begin
        run <= '0;
      end else if (run == 4'(FILTER_LEN - 1)) begin
        level <= sync[1];
        run   <= '0;
      end else begin
        run <= run + 4'd1;
      end
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/i2c_regfile_slave.sv
// CLK-oversampled I2C slave serving a byte-wide register file with
// auto-increment, per-register write strobes and read-only status registers.
module i2c_regfile_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]          DEV_ADDR   = DEFAULT_DEV_ADDR,
  parameter int                  NUM_RW     = 32,
  parameter int                  NUM_RO     = 2,
  parameter logic [8*NUM_RW-1:0] RW_RESET   = '0,
  parameter int                  FILTER_LEN = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  i2c_regfile_slave_if.slave    bus,
  output logic [8*NUM_RW-1:0]   o_regs,
  output logic [NUM_RW-1:0]     o_wr_strobe,
  input  logic [8*NUM_RO-1:0]   i_ro_regs,
  output logic                  o_busy
);

  localparam int RW_AW = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;
  localparam int RO_AW = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start, stop;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(CLK), .rst(RST), .raw(bus.SCL_IN), .level(scl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(CLK), .rst(RST), .raw(bus.SDA_IN), .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  state_e     state, state_next;
  logic [3:0] bit_cnt, cnt_next;
  logic       sda_oe, oe_next;
  logic [7:0] shreg, ptr, tx, rd_byte, rd_ptr, wr_data;
  logic [7:0] regs [NUM_RW];
  logic [7:0] ro   [NUM_RO];
  logic       shift_in, write_byte, index_load, ptr_inc, tx_load, tx_first, tx_shift, wr_ok;
  logic [RW_AW-1:0] w_idx;

  for (genvar k = 0; k < NUM_RW; k++) begin : g_rw
    assign o_regs[8*k +: 8] = regs[k];
  end
  for (genvar k = 0; k < NUM_RO; k++) begin : g_ro
    assign ro[k] = i_ro_regs[8*k +: 8];
  end

  assign wr_data    = {shreg[6:0], sda};
  assign w_idx      = RW_AW'(ptr);
  assign wr_ok      = (read_src(ptr, NUM_RW, NUM_RO) == SRC_RW);
  // A master ACK loads the byte after the current pointer in the same cycle it advances.
  assign rd_ptr     = (state == READ_MACK) ? ptr + 8'd1 : ptr;
  assign bus.SDA_OE = sda_oe;

  always_comb begin
    case (read_src(rd_ptr, NUM_RW, NUM_RO))
      SRC_RW:  rd_byte = regs[RW_AW'(rd_ptr)];
      SRC_RO:  rd_byte = ro[RO_AW'(rd_ptr - 8'(NUM_RW))];
      default: rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next = state;
    cnt_next   = bit_cnt;
    oe_next    = sda_oe;
    shift_in   = 1'b0;
    write_byte = 1'b0;
    index_load = 1'b0;
    ptr_inc    = 1'b0;
    tx_load    = 1'b0;
    tx_first   = 1'b0;
    tx_shift   = 1'b0;
    if (start) begin
      state_next = ADDR;
      cnt_next   = '0;
      oe_next    = 1'b0;
    end else if (stop) begin
      state_next = IDLE;
      oe_next    = 1'b0;
    end else begin
      case (state)
        ADDR, INDEX, WRITE: begin
          if (scl_rise) begin
            shift_in = 1'b1;
            cnt_next = bit_cnt + 4'd1;
            if (state == WRITE && bit_cnt == 4'd7) begin
              write_byte = 1'b1;
              ptr_inc    = 1'b1;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            oe_next = 1'b1;
            case (state)
              ADDR: begin
                if (shreg[7:1] == DEV_ADDR) begin
                  state_next = ADDR_ACK;
                end else begin
                  state_next = IDLE;
                  oe_next    = 1'b0;
                end
              end
              INDEX: begin
                index_load = 1'b1;
                state_next = INDEX_ACK;
              end
              default: state_next = WRITE_ACK;
            endcase
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_next = '0;
            if (shreg[0]) begin
              state_next = READ;
              tx_load    = 1'b1;
              tx_first   = 1'b1;
              oe_next    = ~rd_byte[7];
            end else begin
              state_next = INDEX;
              oe_next    = 1'b0;
            end
          end
        end
        INDEX_ACK, WRITE_ACK: begin
          if (scl_fall) begin
            state_next = WRITE;
            cnt_next   = '0;
            oe_next    = 1'b0;
          end
        end
        READ: begin
          if (scl_rise) begin
            cnt_next = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_next = READ_MACK;
              oe_next    = 1'b0;
            end else begin
              oe_next  = ~tx[7];
              tx_shift = 1'b1;
            end
          end
        end
        READ_MACK: begin
          if (scl_rise) begin
            if (!sda) begin
              ptr_inc    = 1'b1;
              tx_load    = 1'b1;
              state_next = READ;
              cnt_next   = '0;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sda_oe  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
      sda_oe  <= oe_next;
      // Busy holds across a repeated START and is only raised by an address match.
      o_busy  <= (state_next == ADDR) ? o_busy : (state_next != IDLE);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg       <= '0;
      ptr         <= '0;
      tx          <= '0;
      o_wr_strobe <= '0;
      // NOTE: the register file is built from flops and must come out of reset at RW_RESET, so it is reset explicitly.
      for (int k = 0; k < NUM_RW; k++) regs[k] <= RW_RESET[8*k +: 8];
    end else begin
      o_wr_strobe <= '0;
      if (shift_in) shreg <= wr_data;
      if (index_load)   ptr <= shreg;
      else if (ptr_inc) ptr <= ptr + 8'd1;
      if (write_byte && wr_ok) begin
        regs[w_idx]        <= wr_data;
        o_wr_strobe[w_idx] <= 1'b1;
      end
      if (tx_load)       tx <= tx_first ? {rd_byte[6:0], 1'b0} : rd_byte;
      else if (tx_shift) tx <= {tx[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_i2c_regfile_slave.sv
// Directed bit-banged I2C master exercising writes, reads, RO region, wrap, glitch and reset.
module tb_i2c_regfile_slave;
  import i2c_pkg::*;

  localparam int NUM_RW = 32;
  localparam int NUM_RO = 2;
  localparam int Q      = 10;
  localparam logic [8*NUM_RW-1:0] RW_RESET = {NUM_RW{8'h5A}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic [8*NUM_RW-1:0] o_regs;
  logic [NUM_RW-1:0]   o_wr_strobe;
  logic [8*NUM_RO-1:0] ro_regs = 16'hBEEF;
  logic                o_busy;

  i2c_regfile_slave_if bus ();
  assign bus.SCL_IN = scl_m;
  assign bus.SDA_IN = sda_m & ~bus.SDA_OE;

  i2c_regfile_slave #(
    .DEV_ADDR(7'h55), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .RW_RESET(RW_RESET), .FILTER_LEN(3)
  ) dut (
    .CLK(clk), .RST(rst), .bus(bus), .o_regs(o_regs), .o_wr_strobe(o_wr_strobe),
    .i_ro_regs(ro_regs), .o_busy(o_busy)
  );

  int checks = 0;
  int errors = 0;
  int strobe_log[$];
  int multi  = 0;
  int oe_cnt = 0;
  logic [7:0] exp_regs [NUM_RW];

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RW; i++) if (o_wr_strobe[i]) strobe_log.push_back(i);
      if ($countones(o_wr_strobe) > 1) multi++;
      if (bus.SDA_OE) oe_cnt++;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] packed_exp();
    logic [255:0] r;
    for (int k = 0; k < NUM_RW; k++) r[8*k +: 8] = exp_regs[k];
    return r;
  endfunction

  task automatic q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic start_cond();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q(); q();
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    sda_m = b;
    if (glitch) begin
      repeat (3) @(negedge clk);
      scl_m = 1'b1;
      @(negedge clk);
      scl_m = 1'b0;
      repeat (Q - 4) @(negedge clk);
    end else begin
      q();
    end
    scl_m = 1'b1; q(); q();
    scl_m = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit);
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    ack = ~bus.SDA_IN; q();
    scl_m = 1'b0; q();
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      b[i] = bus.SDA_IN; q();
      scl_m = 1'b0; q();
    end
    sda_m = ~mack; q();
    scl_m = 1'b1; q(); q();
    scl_m = 1'b0; q();
    sda_m = 1'b1;
  endtask

  task automatic write_seq(input string tag, input logic [7:0] idx, input logic [7:0] d [4], input int n);
    logic ack;
    start_cond();
    send_byte(8'hAA, -1, ack);
    check({tag, "_addr_ack"}, ack, 1'b1);
    check({tag, "_busy"}, o_busy, 1'b1);
    send_byte(idx, -1, ack);
    check({tag, "_idx_ack"}, ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], -1, ack);
      check({tag, "_data_ack"}, ack, 1'b1);
    end
    stop_cond();
    check({tag, "_busy_after_stop"}, o_busy, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         oe_before;

    for (int k = 0; k < NUM_RW; k++) exp_regs[k] = 8'h5A;
    repeat (5) @(negedge clk);
    check("rst_sda_oe", bus.SDA_OE, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_regs", o_regs, RW_RESET);
    check("rst_strobe", o_wr_strobe, '0);
    check("rst_ptr", dut.ptr, 8'h00);
    check("rst_state", dut.state, IDLE);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // single write to reg 3
    strobe_log.delete();
    write_seq("w3", 8'h03, '{8'h57, 8'h00, 8'h00, 8'h00}, 1);
    exp_regs[3] = 8'h57;
    check("w3_regs", o_regs, packed_exp());
    check("w3_strobe_n", strobe_log.size(), 1);
    check("w3_strobe_idx", strobe_log[0], 3);

    // burst write 5..7
    strobe_log.delete();
    write_seq("w5", 8'h05, '{8'h11, 8'h22, 8'h33, 8'h00}, 3);
    exp_regs[5] = 8'h11; exp_regs[6] = 8'h22; exp_regs[7] = 8'h33;
    check("w5_regs", o_regs, packed_exp());
    check("w5_strobe_n", strobe_log.size(), 3);
    check("w5_strobe_0", strobe_log[0], 5);
    check("w5_strobe_1", strobe_log[1], 6);
    check("w5_strobe_2", strobe_log[2], 7);

    // index 3, repeated START, read two bytes
    start_cond();
    send_byte(8'hAA, -1, ack); check("rs_addr_ack", ack, 1'b1);
    send_byte(8'h03, -1, ack); check("rs_idx_ack", ack, 1'b1);
    start_cond();
    send_byte(8'hAB, -1, ack); check("rs_raddr_ack", ack, 1'b1);
    recv_byte(1'b1, rd); check("rs_rd0", rd, 8'h57);
    recv_byte(1'b0, rd); check("rs_rd1", rd, 8'h5A);
    check("rs_sda_released", bus.SDA_OE, 1'b0);
    check("rs_state_idle", dut.state, IDLE);
    check("rs_busy", o_busy, 1'b0);
    check("rs_ptr", dut.ptr, 8'h04);
    stop_cond();

    // read-only region and unmapped index
    start_cond();
    send_byte(8'hAA, -1, ack);
    send_byte(8'h20, -1, ack); check("ro_idx_ack", ack, 1'b1);
    start_cond();
    send_byte(8'hAB, -1, ack); check("ro_raddr_ack", ack, 1'b1);
    recv_byte(1'b1, rd); check("ro_rd20", rd, 8'hEF);
    recv_byte(1'b1, rd); check("ro_rd21", rd, 8'hBE);
    recv_byte(1'b0, rd); check("ro_rd22", rd, 8'h00);
    stop_cond();
    strobe_log.delete();
    write_seq("ro_wr", 8'h20, '{8'h99, 8'h00, 8'h00, 8'h00}, 1);
    check("ro_wr_no_strobe", strobe_log.size(), 0);
    check("ro_wr_regs", o_regs, packed_exp());
    // pointer retained across STOP: now 0x21
    start_cond();
    send_byte(8'hAB, -1, ack); check("ret_raddr_ack", ack, 1'b1);
    recv_byte(1'b0, rd); check("ret_rd21", rd, 8'hBE);
    stop_cond();

    // foreign address
    oe_before = oe_cnt;
    start_cond();
    send_byte(8'hA8, -1, ack); check("na_ack", ack, 1'b0);
    check("na_busy", o_busy, 1'b0);
    send_byte(8'h12, -1, ack); check("na_ack2", ack, 1'b0);
    stop_cond();
    check("na_oe_never", oe_cnt, oe_before);
    check("na_regs", o_regs, packed_exp());

    // 1-cycle SCL glitch inside a data byte
    start_cond();
    send_byte(8'hAA, -1, ack);
    send_byte(8'h08, -1, ack);
    send_byte(8'hC3, 4, ack); check("gl_ack", ack, 1'b1);
    stop_cond();
    exp_regs[8] = 8'hC3;
    check("gl_regs", o_regs, packed_exp());

    // pointer wrap 0xFF -> 0x00
    strobe_log.delete();
    write_seq("wrap", 8'hFF, '{8'h77, 8'h66, 8'h00, 8'h00}, 2);
    exp_regs[0] = 8'h66;
    check("wrap_regs", o_regs, packed_exp());
    check("wrap_strobe_n", strobe_log.size(), 1);
    check("wrap_strobe_idx", strobe_log[0], 0);

    // reset in the middle of a read while SDA is driven low (reg5 = 0x11)
    start_cond();
    send_byte(8'hAA, -1, ack);
    send_byte(8'h05, -1, ack);
    start_cond();
    send_byte(8'hAB, -1, ack);
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    check("mr_driving", bus.SDA_OE, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mr_sda_oe", bus.SDA_OE, 1'b0);
    check("mr_regs", o_regs, RW_RESET);
    check("mr_ptr", dut.ptr, 8'h00);
    check("mr_state", dut.state, IDLE);
    rst = 1'b0;
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (20) @(negedge clk);
    for (int k = 0; k < NUM_RW; k++) exp_regs[k] = 8'h5A;

    // recovery after reset
    write_seq("rec", 8'h01, '{8'h42, 8'h00, 8'h00, 8'h00}, 1);
    exp_regs[1] = 8'h42;
    check("rec_regs", o_regs, packed_exp());
    check("onehot_strobe", multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
